except_collector: RTL

EXCEPT_COLLECTOR -- requirements
Module: except_collector

---
 rtl/except_collector.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/except_collector.sv
// except_collector: three-stage IF/ID/EX pipeline that gathers exception flags into a prioritized CP0 excepttype word.
// Define ALIGN_CHECK_EN to compute adel/ades internally from ex_size and ex_mem_addr instead of using ex_adel/ex_ades.
module except_collector #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              id_syscall,
  input  logic              id_break,
  input  logic              id_invalid,
  input  logic              id_eret,
  input  logic              id_mfc0,
  input  logic              id_mtc0,
  input  logic              id_branch,
  input  logic [4:0]        id_cp0_addr,
  input  logic              ex_overflow,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [1:0]        ex_size,
  input  logic [DATA_W-1:0] ex_mem_addr,
  input  logic              ex_adel,
  input  logic              ex_ades,
  output logic [15:0]       excepttype,
  output logic [DATA_W-1:0] current_pc,
  output logic [DATA_W-1:0] bad_addr,
  output logic              exc_valid
);

  // Keeps only the lowest set bit; bit 0 carries the highest-priority exception.
  function automatic logic [6:0] first_set(input logic [6:0] f);
    return f & (~f + 7'd1);
  endfunction

`ifdef ALIGN_CHECK_EN
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b01:   return lo[0];
      2'b10:   return |lo;
      default: return 1'b0;
    endcase
  endfunction
`endif

  logic              vld_p0;
  logic              pc_addr_p0;
  logic [DATA_W-1:0] pc_p0;

  logic              vld_p1;
  logic              pc_addr_p1;
  logic              ri_p1;
  logic              sys_p1;
  logic              brk_p1;
  logic              eret_p1;
  logic              mfc0_p1;
  logic              mtc0_p1;
  logic              ds_p1;
  logic [4:0]        cp0_p1;
  logic [DATA_W-1:0] pc_p1;

  logic              vld_p2;
  logic [15:0]       et_p2;
  logic [DATA_W-1:0] pc_p2;
  logic [DATA_W-1:0] bad_p2;

  logic              branch_pending;
  logic              id_take;

  assign id_take = vld_p0 & ~pc_addr_p0;

  // IF -> ID and ID -> EX control registers
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p0         <= 1'b0;
      pc_addr_p0     <= 1'b0;
      vld_p1         <= 1'b0;
      pc_addr_p1     <= 1'b0;
      ri_p1          <= 1'b0;
      sys_p1         <= 1'b0;
      brk_p1         <= 1'b0;
      eret_p1        <= 1'b0;
      mfc0_p1        <= 1'b0;
      mtc0_p1        <= 1'b0;
      ds_p1          <= 1'b0;
      branch_pending <= 1'b0;
    end else if (!stall) begin
      vld_p0     <= if_valid;
      pc_addr_p0 <= if_valid & (if_pc[1:0] != 2'b00);
      vld_p1     <= vld_p0;
      pc_addr_p1 <= vld_p0 & pc_addr_p0;
      ri_p1      <= id_take & id_invalid;
      sys_p1     <= id_take & id_syscall;
      brk_p1     <= id_take & id_break;
      eret_p1    <= id_take & id_eret;
      mfc0_p1    <= id_take & id_mfc0;
      mtc0_p1    <= id_take & id_mtc0;
      ds_p1      <= id_take & branch_pending;
      if (vld_p0) branch_pending <= id_branch;
    end
  end

  // PCs and CP0 number are qualified by the valid bits, so they need no reset
  always_ff @(posedge clk) begin
    if (!stall) begin
      pc_p0  <= if_pc;
      pc_p1  <= pc_p0;
      cp0_p1 <= id_take ? id_cp0_addr : 5'd0;
    end
  end

  logic adel_raw;
  logic ades_raw;
  logic unused_ext;

`ifdef ALIGN_CHECK_EN
  assign adel_raw   = ex_load  & misaligned(ex_size, ex_mem_addr[1:0]);
  assign ades_raw   = ex_store & misaligned(ex_size, ex_mem_addr[1:0]);
  assign unused_ext = ex_adel ^ ex_ades;
`else
  assign adel_raw   = ex_adel & ex_load;
  assign ades_raw   = ex_ades & ex_store;
  assign unused_ext = ^ex_size;
`endif

  logic [6:0]        hit;
  logic              exc_any;
  logic [15:0]       et_nxt;
  logic [DATA_W-1:0] pc_nxt;
  logic [DATA_W-1:0] bad_nxt;

  always_comb begin
    hit     = '0;
    et_nxt  = '0;
    pc_nxt  = '0;
    bad_nxt = '0;
    exc_any = 1'b0;
    if (vld_p1) begin
      hit     = first_set({ades_raw, adel_raw, ex_overflow, brk_p1, sys_p1, ri_p1, pc_addr_p1});
      exc_any = |hit;
      et_nxt  = {cp0_p1, ds_p1, hit[0], hit[6], hit[5], hit[4], hit[2], hit[3], hit[1],
                 eret_p1 & ~exc_any, mfc0_p1 & ~exc_any, mtc0_p1 & ~exc_any};
      pc_nxt  = pc_p1;
      if (hit[0])              bad_nxt = pc_p1;
      else if (hit[5] | hit[6]) bad_nxt = ex_mem_addr;
    end
  end

  // EX -> OUT register; a stall pushes a bubble here
  always_ff @(posedge clk) begin
    if (rst || flush || stall) begin
      vld_p2 <= 1'b0;
      et_p2  <= '0;
      pc_p2  <= '0;
      bad_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      et_p2  <= et_nxt;
      pc_p2  <= pc_nxt;
      bad_p2 <= bad_nxt;
    end
  end

  assign excepttype = et_p2;
  assign current_pc = pc_p2;
  assign bad_addr   = bad_p2;
  assign exc_valid  = vld_p2;

endmodule
